multicycle_control: RTL and testbench

Main control FSM that sequences the MIPS datapath over multiple cycles per instruction: fetch, decode, execute, memory and writeback. It drives every datapath select and write enable from the current state and the instruction opcode. It waits on a single-bit memory-ready handshake, so it can sit in front of a shared instruction/data memory with variable latency. It also counts retired instructions and flags illegal opcodes.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/control_decode.sv | 91 +++++++++
 rtl/multicycle_control.sv | 105 ++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, controller states, datapath select
// encodings and the control word passed from the decoder to the top level.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
    logic       retired;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decode for the multicycle controller: Moore outputs
// from state, with mem_ready qualifying the handshake states and op flagging illegals.
module control_decode
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only advance once the fetch data is actually back
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_legal(op);
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.retired    = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retired   = mem_ready;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.retired    = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retired       = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retired   = 1'b1;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      I_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.retired    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state sequencing,
// retired-instruction counter and reset gating of the decoded control word.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegal_op,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_nxt;
  ctrl_t  ctrl, ctrl_g;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_RTYPE:     state_nxt = R_EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_ADDI:      state_nxt = I_EXEC;
          default:      state_nxt = FETCH;
        endcase
      end
      MEM_ADDR:  state_nxt = (op == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) state_nxt = MEM_WB;
      MEM_WRITE: if (mem_ready) state_nxt = FETCH;
      R_EXEC:    state_nxt = R_WB;
      I_EXEC:    state_nxt = I_WB;
      default:   state_nxt = FETCH;
    endcase
  end

  control_decode u_dec (
    .state     (state),
    .op        (op),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset leaves state at FETCH, which would otherwise request memory; squash
  // every side-effecting strobe while reset is held.
  always_comb begin
    ctrl_g = ctrl;
    if (reset) begin
      ctrl_g.pc_write      = 1'b0;
      ctrl_g.pc_write_cond = 1'b0;
      ctrl_g.ir_write      = 1'b0;
      ctrl_g.mem_read      = 1'b0;
      ctrl_g.mem_write     = 1'b0;
      ctrl_g.reg_write     = 1'b0;
      ctrl_g.illegal_op    = 1'b0;
      ctrl_g.retired       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               instr_count <= '0;
    else if (ctrl_g.retired) instr_count <= instr_count + CNT_W'(1);
  end

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign IRWrite     = ctrl_g.ir_write;
  assign PCSource    = ctrl_g.pc_source;
  assign ALUOp       = ctrl_g.alu_op;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign RegWrite    = ctrl_g.reg_write;
  assign RegDst      = ctrl_g.reg_dst;
  assign illegal_op  = ctrl_g.illegal_op;
  assign retired     = ctrl_g.retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-word checks
// against hand-written expected vectors, plus async reset and counter wrap.
module tb_multicycle_control;
  import mips_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic             ALUSrcA, RegWrite, RegDst, illegal_op, retired;
  logic [CNT_W-1:0] instr_count;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .retired(retired),
    .instr_count(instr_count)
  );

  // {pcw,pcwc,iord,mrd,mwr,m2r,irw,pcsrc[2],aluop[2],srca,srcb[2],rw,rdst,ill,ret}
  wire [17:0] ov = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op, retired};

  localparam logic [17:0] V_F1  = 18'b1_0_0_1_0_0_1_00_00_0_01_0_0_0_0;
  localparam logic [17:0] V_F0  = 18'b0_0_0_1_0_0_0_00_00_0_01_0_0_0_0;
  localparam logic [17:0] V_DEC = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_0;
  localparam logic [17:0] V_DIL = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_1_0;
  localparam logic [17:0] V_MAD = 18'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_0;
  localparam logic [17:0] V_MRD = 18'b0_0_1_1_0_0_0_00_00_0_00_0_0_0_0;
  localparam logic [17:0] V_MWB = 18'b0_0_0_0_0_1_0_00_00_0_00_1_0_0_1;
  localparam logic [17:0] V_MW0 = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_0_0;
  localparam logic [17:0] V_MW1 = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_0_1;
  localparam logic [17:0] V_REX = 18'b0_0_0_0_0_0_0_00_10_1_00_0_0_0_0;
  localparam logic [17:0] V_RWB = 18'b0_0_0_0_0_0_0_00_00_0_00_1_1_0_1;
  localparam logic [17:0] V_BR  = 18'b0_1_0_0_0_0_0_01_01_1_00_0_0_0_1;
  localparam logic [17:0] V_JMP = 18'b1_0_0_0_0_0_0_10_00_0_00_0_0_0_1;
  localparam logic [17:0] V_IEX = 18'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_0;
  localparam logic [17:0] V_IWB = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_0_1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the current cycle (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input state_t es, input logic [17:0] ev);
    #1;
    chk({tag, ".state"}, 32'(dut.state), 32'(es));
    chk({tag, ".ctrl"}, 32'(ov), 32'(ev));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(dut.state), 32'(FETCH));
    chk("rst.ctrl_en", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
                             illegal_op, retired}), 32'h0);
    chk("rst.cnt", 32'(instr_count), 32'h0);
    reset = 1'b0;

    // lw, mem_ready high throughout: 5 cycles
    op = OP_LW; mem_ready = 1'b1;
    cyc("lw.c1", FETCH, V_F1);
    cyc("lw.c2", DECODE, V_DEC);
    cyc("lw.c3", MEM_ADDR, V_MAD);
    cyc("lw.c4", MEM_READ, V_MRD);
    cyc("lw.c5", MEM_WB, V_MWB);
    chk("lw.cnt", 32'(instr_count), 32'd1);

    // sw with three wait cycles in MEM_WRITE: 7 cycles
    op = OP_SW;
    cyc("sw.c1", FETCH, V_F1);
    cyc("sw.c2", DECODE, V_DEC);
    cyc("sw.c3", MEM_ADDR, V_MAD);
    mem_ready = 1'b0;
    cyc("sw.w1", MEM_WRITE, V_MW0);
    cyc("sw.w2", MEM_WRITE, V_MW0);
    cyc("sw.w3", MEM_WRITE, V_MW0);
    mem_ready = 1'b1;
    cyc("sw.w4", MEM_WRITE, V_MW1);
    chk("sw.cnt", 32'(instr_count), 32'd2);

    // R, beq, j, addi back to back: 14 cycles
    op = OP_RTYPE;
    cyc("r.c1", FETCH, V_F1);
    cyc("r.c2", DECODE, V_DEC);
    cyc("r.c3", R_EXEC, V_REX);
    cyc("r.c4", R_WB, V_RWB);
    op = OP_BEQ;
    cyc("beq.c1", FETCH, V_F1);
    cyc("beq.c2", DECODE, V_DEC);
    cyc("beq.c3", BRANCH, V_BR);
    op = OP_J;
    cyc("j.c1", FETCH, V_F1);
    cyc("j.c2", DECODE, V_DEC);
    cyc("j.c3", JUMP, V_JMP);
    op = OP_ADDI;
    cyc("addi.c1", FETCH, V_F1);
    cyc("addi.c2", DECODE, V_DEC);
    cyc("addi.c3", I_EXEC, V_IEX);
    cyc("addi.c4", I_WB, V_IWB);
    chk("seq.cnt", 32'(instr_count), 32'd6);

    // fetch stall for 2 cycles, then illegal opcode
    op = 6'h3F; mem_ready = 1'b0;
    cyc("ill.f1", FETCH, V_F0);
    cyc("ill.f2", FETCH, V_F0);
    mem_ready = 1'b1;
    cyc("ill.f3", FETCH, V_F1);
    cyc("ill.dec", DECODE, V_DIL);
    #1;
    chk("ill.back", 32'(dut.state), 32'(FETCH));
    chk("ill.cnt", 32'(instr_count), 32'd6);

    // async reset while waiting in MEM_READ
    op = OP_LW;
    cyc("ar.c1", FETCH, V_F1);
    cyc("ar.c2", DECODE, V_DEC);
    cyc("ar.c3", MEM_ADDR, V_MAD);
    mem_ready = 1'b0;
    #2;
    chk("ar.pre", 32'(dut.state), 32'(MEM_READ));
    reset = 1'b1;
    #1;
    chk("ar.state", 32'(dut.state), 32'(FETCH));
    chk("ar.en", 32'({MemRead, RegWrite}), 32'h0);
    chk("ar.cnt", 32'(instr_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    chk("ar.fetch", 32'(MemRead), 32'd1);

    // counter wrap at CNT_W=4: 15 jumps reach all-ones, the 16th wraps to 0
    op = OP_J;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    chk("wrap.15", 32'(instr_count), 32'd15);
    cyc("wrap.f", FETCH, V_F1);
    cyc("wrap.d", DECODE, V_DEC);
    cyc("wrap.j", JUMP, V_JMP);
    chk("wrap.0", 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
